nibble_parity_rx: RTL and testbench

//  Serial receiver for the nibble link. The transmit side sends nibble frames,
//  and each parity bit is the XOR-reduction of the data bits (Buffer-style ^a).

---
 rtl/nibble_parity_rx.sv | 123 ++++++++++++
 tb/tb_nibble_parity_rx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_parity_rx.sv
// Serial receiver for the nibble link: start/data/parity/stop deserializer with
// parity and framing checks, a valid/ready holding register and a saturating error counter.
module nibble_parity_rx #(
  parameter int DW   = 4,
  parameter int ERRW = 8
) (
  input  logic            CLK_w,
  input  logic            RST,
  input  logic            SEN,
  input  logic            SDI,
  input  logic            CLR_CNT,
  input  logic            DREADY,
  output logic [DW-1:0]   DOUT,
  output logic            DVALID,
  output logic            PERR,
  output logic            FERR,
  output logic            OVR,
  output logic            BUSY,
  output logic [ERRW-1:0] ERR_CNT
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   shreg_q;
  logic            par_q;

  logic            frame_done;
  logic            load;
  logic            drop;
  logic            perr_new;
  logic            ferr_new;
  logic            err_inc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK_w or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      BUSY    <= (state_d != IDLE);
    end
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (SEN) begin
      case (state_q)
        IDLE:    if (!SDI) state_d = DATA;
        DATA:    if (cnt_q == CW'(DW - 1)) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_w or negedge RST) begin
    if (!RST) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else if (SEN) begin
      case (state_q)
        IDLE: cnt_q <= '0;
        DATA: begin
          shreg_q[cnt_q] <= SDI;
          cnt_q          <= cnt_q + 1'b1;
        end
        PARITY: par_q <= SDI;
        default: ;
      endcase
    end
  end

  // The stop bit is used directly on its sample cycle; it is never stored.
  assign frame_done = SEN && (state_q == STOP);
  assign load       = frame_done && (!DVALID || DREADY);
  assign drop       = frame_done && DVALID && !DREADY;
  assign perr_new   = (^shreg_q) != par_q;
  assign ferr_new   = ~SDI;
  assign err_inc    = drop || (load && (perr_new || ferr_new));

  always_ff @(posedge CLK_w or negedge RST) begin
    if (!RST) begin
      DOUT   <= '0;
      DVALID <= 1'b0;
      PERR   <= 1'b0;
      FERR   <= 1'b0;
    end else if (load) begin
      DOUT   <= shreg_q;
      DVALID <= 1'b1;
      PERR   <= perr_new;
      FERR   <= ferr_new;
    end else if (DVALID && DREADY) begin
      DVALID <= 1'b0;
    end
  end

  // A frame that is both errored and dropped still counts only once.
  always_ff @(posedge CLK_w or negedge RST) begin
    if (!RST) begin
      ERR_CNT <= '0;
      OVR     <= 1'b0;
    end else if (CLR_CNT) begin
      ERR_CNT <= '0;
      OVR     <= 1'b0;
    end else begin
      if (err_inc && (ERR_CNT != {ERRW{1'b1}}))
        ERR_CNT <= ERR_CNT + 1'b1;
      if (drop)
        OVR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nibble_parity_rx.sv
// Self-checking bench for nibble_parity_rx: scoreboard of delivered frames plus
// direct checks of latency, overrun, counter saturation/clear and mid-frame reset.
module tb_nibble_parity_rx;

  localparam int DW = 4;

  logic          CLK_w = 1'b0;
  logic          RST = 1'b0;
  logic          SEN = 1'b0;
  logic          SDI = 1'b1;
  logic          CLR_CNT = 1'b0;
  logic          DREADY = 1'b0;

  logic [DW-1:0] DOUT;
  logic          DVALID, PERR, FERR, OVR, BUSY;
  logic [7:0]    ERR_CNT;

  logic [DW-1:0] s_dout;
  logic          s_dvalid, s_perr, s_ferr, s_ovr, s_busy;
  logic [1:0]    s_err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  nibble_parity_rx #(.DW(DW), .ERRW(8)) dut (
    .CLK_w(CLK_w), .RST(RST), .SEN(SEN), .SDI(SDI), .CLR_CNT(CLR_CNT),
    .DREADY(DREADY), .DOUT(DOUT), .DVALID(DVALID), .PERR(PERR), .FERR(FERR),
    .OVR(OVR), .BUSY(BUSY), .ERR_CNT(ERR_CNT)
  );

  nibble_parity_rx #(.DW(DW), .ERRW(2)) dut_sat (
    .CLK_w(CLK_w), .RST(RST), .SEN(SEN), .SDI(SDI), .CLR_CNT(CLR_CNT),
    .DREADY(DREADY), .DOUT(s_dout), .DVALID(s_dvalid), .PERR(s_perr), .FERR(s_ferr),
    .OVR(s_ovr), .BUSY(s_busy), .ERR_CNT(s_err_cnt)
  );

  always #5 CLK_w = ~CLK_w;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock with the given strobe/data; returns 1 time unit after the edge.
  task automatic cyc(input logic sen, input logic sdi);
    SEN = sen;
    SDI = sdi;
    @(posedge CLK_w);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_dout"},    32'(DOUT),      32'd0);
    check({pfx, "_dvalid"},  32'(DVALID),    32'd0);
    check({pfx, "_perr"},    32'(PERR),      32'd0);
    check({pfx, "_ferr"},    32'(FERR),      32'd0);
    check({pfx, "_ovr"},     32'(OVR),       32'd0);
    check({pfx, "_busy"},    32'(BUSY),      32'd0);
    check({pfx, "_err_cnt"}, 32'(ERR_CNT),   32'd0);
    check({pfx, "_s_cnt"},   32'(s_err_cnt), 32'd0);
    check({pfx, "_s_ovr"},   32'(s_ovr),     32'd0);
  endtask

  task automatic apply_reset();
    RST     = 1'b0;
    SEN     = 1'b0;
    SDI     = 1'b1;
    CLR_CNT = 1'b0;
    #3;
    check_all_zero("rst");
    sb.delete();
    @(posedge CLK_w);
    #1;
    RST = 1'b1;
  endtask

  // Sends start, DW data bits LSB first, parity, stop. gap = SEN=0 cycles
  // before each post-start bit, during which SDI is randomised.
  task automatic send_frame(input logic [DW-1:0] data, input logic bad_p, input logic bad_s,
                            input int gap, input logic rdy_on_stop, input logic clr_on_stop,
                            input logic push);
    logic [DW+2:0] bits;
    bits = {~bad_s, (^data) ^ bad_p, data, 1'b0};
    if (push) sb.push_back({data, bad_p, bad_s});
    for (int k = 0; k < DW + 3; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          cyc(1'b0, 1'($urandom));
          check("busy_gap", 32'(BUSY), 32'd1);
        end
      end
      if (k == DW + 2) begin
        if (rdy_on_stop) DREADY = 1'b1;
        if (clr_on_stop) CLR_CNT = 1'b1;
      end
      cyc(1'b1, bits[k]);
      CLR_CNT = 1'b0;
    end
    SEN = 1'b0;
    SDI = 1'b1;
  endtask

  // Scoreboard: every accepted output must match the oldest expected frame.
  always @(negedge CLK_w) begin
    if (RST && DVALID && DREADY) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check("sb_dout", 32'(DOUT), 32'(mon_e.data));
        check("sb_perr", 32'(PERR), 32'(mon_e.perr));
        check("sb_ferr", 32'(FERR), 32'(mon_e.ferr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply_reset();

    // Clean frame, one-cycle valid pulse
    DREADY = 1'b1;
    send_frame(4'hA, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("t1_dvalid",  32'(DVALID),  32'd1);
    check("t1_dout",    32'(DOUT),    32'hA);
    check("t1_perr",    32'(PERR),    32'd0);
    check("t1_ferr",    32'(FERR),    32'd0);
    check("t1_err_cnt", 32'(ERR_CNT), 32'd0);
    check("t1_busy",    32'(BUSY),    32'd0);
    cyc(1'b0, 1'b1);
    check("t1_dvalid_drop", 32'(DVALID), 32'd0);
    idle(2);

    // Parity error, then framing error
    send_frame(4'h7, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("t2_dout",    32'(DOUT),    32'h7);
    check("t2_perr",    32'(PERR),    32'd1);
    check("t2_err_cnt", 32'(ERR_CNT), 32'd1);
    idle(2);
    send_frame(4'h3, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    check("t2_ferr",     32'(FERR),    32'd1);
    check("t2_perr_ok",  32'(PERR),    32'd0);
    check("t2_err_cnt2", 32'(ERR_CNT), 32'd2);
    idle(2);

    // Overrun with a held frame, then a load coinciding with acceptance
    DREADY = 1'b0;
    send_frame(4'h1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);
    send_frame(4'h2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("t3_dout_held", 32'(DOUT),    32'h1);
    check("t3_dvalid",    32'(DVALID),  32'd1);
    check("t3_ovr",       32'(OVR),     32'd1);
    check("t3_err_cnt",   32'(ERR_CNT), 32'd3);
    send_frame(4'h4, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    check("t3_b2b_dvalid", 32'(DVALID),  32'd1);
    check("t3_b2b_dout",   32'(DOUT),    32'h4);
    check("t3_b2b_cnt",    32'(ERR_CNT), 32'd3);
    idle(2);

    // Sparse strobe: SEN one cycle in three
    check("t4_busy_pre", 32'(BUSY), 32'd0);
    send_frame(4'hC, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1);
    check("t4_dvalid",  32'(DVALID),  32'd1);
    check("t4_dout",    32'(DOUT),    32'hC);
    check("t4_perr",    32'(PERR),    32'd0);
    check("t4_busy",    32'(BUSY),    32'd0);
    check("t4_err_cnt", 32'(ERR_CNT), 32'd3);
    idle(2);

    // Saturation of the 2-bit counter, clear beating a coincident increment
    apply_reset();
    DREADY = 1'b0;
    send_frame(4'h9, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);
    send_frame(4'h6, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("t5_ovr",   32'(OVR),   32'd1);
    check("t5_s_ovr", 32'(s_ovr), 32'd1);
    DREADY = 1'b1;
    idle(2);
    send_frame(4'hB, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(2);
    send_frame(4'hD, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(2);
    send_frame(4'hE, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("t5_s_sat",   32'(s_err_cnt), 32'd3);
    check("t5_err_cnt", 32'(ERR_CNT),   32'd5);
    idle(2);
    send_frame(4'hF, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    check("t5_clr_cnt",   32'(ERR_CNT),   32'd0);
    check("t5_clr_s_cnt", 32'(s_err_cnt), 32'd0);
    check("t5_clr_ovr",   32'(OVR),       32'd0);
    check("t5_clr_s_ovr", 32'(s_ovr),     32'd0);
    check("t5_perr",      32'(PERR),      32'd1);
    idle(2);

    // Reset in the middle of a frame
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    check("t6_busy_mid", 32'(BUSY), 32'd1);
    SEN = 1'b0;
    SDI = 1'b1;
    RST = 1'b0;
    #2;
    check_all_zero("t6_rst");
    @(posedge CLK_w);
    #1;
    RST = 1'b1;
    idle(1);
    check("t6_busy_post", 32'(BUSY), 32'd0);
    send_frame(4'h5, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("t6_dvalid",  32'(DVALID),  32'd1);
    check("t6_dout",    32'(DOUT),    32'h5);
    check("t6_perr",    32'(PERR),    32'd0);
    check("t6_ferr",    32'(FERR),    32'd0);
    check("t6_err_cnt", 32'(ERR_CNT), 32'd0);
    idle(3);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
